pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller that owns the program counter's pcload/pcinc/databus interface.
- Arbitrates three requesters for the PC: the interrupt vector, branch/jump targets from execute, and sequential fetch advance.
- Generates the exact command/data cycle sequence the PC needs: a 1-cycle load strobe, then LSW, then MSW on the 16-bit databus, or a 1-cycle increment strobe.
- Sits between fetch/execute/interrupt logic and the PC. It is the only driver of the PC control pins.

Parameters:
BOOT_ADDR, 23'h000000, address loaded into the PC once after reset; 0 means no boot load (the PC already resets to 0)
VEC_BASE, 23'h000004, base of the interrupt vector table; vector address = VEC_BASE + {irq_idx_i, 1'b0}

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
inc_req_i  in  1  fetch requests PC advance by one instruction word
inc_ack_o  out  1  1-cycle pulse: increment granted
br_req_i  in  1  execute requests a jump
br_target_i  in  23  jump target; bit 0 ignored
br_ack_o  out  1  1-cycle pulse: jump granted, target captured
irq_req_i  in  1  interrupt controller requests a vector fetch
irq_idx_i  in  7  vector index
irq_ack_o  out  1  1-cycle pulse: vector granted
stall_i  in  1  blocks new grants; an in-flight sequence always completes
pcload_o  out  1  PC load strobe
pcinc_o  out  1  PC increment strobe
databus_o  out  16  address word to the PC
databus_oe_o  out  1  databus drive enable
busy_o  out  1  high whenever state != StIdle

Behaviour:
- Reset (async): state=StIdle; target=0; all outputs 0; boot_pending set iff BOOT_ADDR!=0. Reset mid-sequence abandons the sequence silently. Requesters hold req until ack, so they re-arbitrate after reset.
- All outputs are registered and Moore-decoded from state.
- Requests are levels. A req must stay high with stable data until its ack.
- Arbitration happens in StIdle only, when stall_i=0. Priority: boot_pending > irq > br > inc. Only one grant per arbitration. Losers wait.
- Target capture at grant:
  - boot: BOOT_ADDR
  - irq: (VEC_BASE + {irq_idx_i,1'b0}) mod 2^23
  - br: br_target_i
  - In all cases, bit 0 of the captured target is forced to 0.
- State sequence, where N is the arbitration cycle in StIdle:
  - Load (boot/irq/br):
    - N+1 StLdCmd: pcload_o=1; the winner's ack=1 (boot has no ack, and boot_pending clears).
    - N+2 StLdLsw: databus_oe_o=1; databus_o=target[15:0].
    - N+3 StLdMsw: databus_oe_o=1; databus_o={9'b0,target[22:16]}.
    - N+4 StIdle.
  - Increment:
    - N+1 StIncCmd: pcinc_o=1; inc_ack_o=1.
    - N+2 StIncWait: all strobes 0.
    - N+3 StIdle.
- Throughput: one load per 4 cycles; one increment per 3 cycles. The PC is always back in its idle state before the next strobe.
- When databus_oe_o=0, databus_o=16'h0000.
- pcload_o and pcinc_o are never high together. Each is high for exactly one cycle per grant.
- Requests arriving mid-sequence (including a higher priority) do not preempt; they are evaluated at the next StIdle.
- stall_i high in StIdle: no grant, no strobe, no ack. stall_i is ignored outside StIdle.
- An illegal state goes to StIdle with outputs 0.

Test Plan:
1. Reset with BOOT_ADDR=23'h000200, no requests -> pcload_o pulses at cycle 1, then databus 16'h0200, then 16'h0000, with oe high for 2 cycles; no acks; then idle with busy_o=0.
2. inc_req_i held high for 7 cycles (BOOT_ADDR=0) -> pcinc_o/inc_ack_o pulse at cycles 1 and 4; pcinc_o is never in consecutive or adjacent cycles.
3. br_req_i with br_target_i=23'h12345B -> pcload_o, then databus 16'h345A, then 16'h0012; br_ack_o coincident with pcload_o.
4. irq_req_i, br_req_i, inc_req_i all asserted together with irq_idx_i=7'h03 -> irq wins: databus 16'h000A then 16'h0000; br grant 4 cycles later, inc grant 4 cycles after that.
5. stall_i=1 for 5 cycles with inc_req_i high -> no strobes or acks. stall_i raised during StLdLsw -> MSW is still driven next cycle.
6. rst_ni asserted during StLdLsw -> outputs 0 immediately; after release with br_req_i still high, a full load sequence of 3 cycles restarts.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: arbitrates boot, interrupt vector, branch and fetch-advance requests
// and drives the program counter's load/increment strobes and 16-bit address databus.
module pc_sequencer #(
    parameter logic [22:0] BOOT_ADDR = 23'h000000,
    parameter logic [22:0] VEC_BASE  = 23'h000004
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_req_i,
    output logic        inc_ack_o,
    input  logic        br_req_i,
    input  logic [22:0] br_target_i,
    output logic        br_ack_o,
    input  logic        irq_req_i,
    input  logic [6:0]  irq_idx_i,
    output logic        irq_ack_o,
    input  logic        stall_i,
    output logic        pcload_o,
    output logic        pcinc_o,
    output logic [15:0] databus_o,
    output logic        databus_oe_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLdCmd   = 3'd1,
        StLdLsw   = 3'd2,
        StLdMsw   = 3'd3,
        StIncCmd  = 3'd4,
        StIncWait = 3'd5
    } state_t;

    state_t      r_state;
    logic [22:0] r_target;
    logic        r_boot_pending;
    logic        r_pcload;
    logic        r_pcinc;
    logic        r_inc_ack;
    logic        r_br_ack;
    logic        r_irq_ack;
    logic        r_oe;
    logic [15:0] r_databus;
    logic        r_busy;

    logic        w_arb_en;
    logic        w_grant_boot;
    logic        w_grant_irq;
    logic        w_grant_br;
    logic        w_grant_inc;
    logic        w_grant_load;
    logic [22:0] w_irq_vec;
    logic [22:0] w_cap_target;

    // Fixed priority boot > irq > br > inc, only while idle and not stalled.
    assign w_arb_en     = (r_state == StIdle) && !stall_i;
    assign w_grant_boot = w_arb_en && r_boot_pending;
    assign w_grant_irq  = w_arb_en && !r_boot_pending && irq_req_i;
    assign w_grant_br   = w_arb_en && !r_boot_pending && !irq_req_i && br_req_i;
    assign w_grant_inc  = w_arb_en && !r_boot_pending && !irq_req_i && !br_req_i && inc_req_i;
    assign w_grant_load = w_grant_boot || w_grant_irq || w_grant_br;

    assign w_irq_vec    = VEC_BASE + {15'b0, irq_idx_i, 1'b0};
    assign w_cap_target = r_boot_pending ? BOOT_ADDR :
                          irq_req_i      ? w_irq_vec : br_target_i;

    // Next state and all outputs are registered together so outputs track the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= StIdle;
            r_target       <= '0;
            r_boot_pending <= (BOOT_ADDR != 23'h0);
            r_pcload       <= 1'b0;
            r_pcinc        <= 1'b0;
            r_inc_ack      <= 1'b0;
            r_br_ack       <= 1'b0;
            r_irq_ack      <= 1'b0;
            r_oe           <= 1'b0;
            r_databus      <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_pcload  <= 1'b0;
            r_pcinc   <= 1'b0;
            r_inc_ack <= 1'b0;
            r_br_ack  <= 1'b0;
            r_irq_ack <= 1'b0;
            r_oe      <= 1'b0;
            r_databus <= '0;
            r_busy    <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant_load) begin
                        r_state   <= StLdCmd;
                        r_target  <= w_cap_target & 23'h7FFFFE;
                        r_pcload  <= 1'b1;
                        r_irq_ack <= w_grant_irq;
                        r_br_ack  <= w_grant_br;
                        r_busy    <= 1'b1;
                        if (w_grant_boot) begin
                            r_boot_pending <= 1'b0;
                        end
                    end else if (w_grant_inc) begin
                        r_state   <= StIncCmd;
                        r_pcinc   <= 1'b1;
                        r_inc_ack <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                StLdCmd: begin
                    r_state   <= StLdLsw;
                    r_oe      <= 1'b1;
                    r_databus <= r_target[15:0];
                    r_busy    <= 1'b1;
                end
                StLdLsw: begin
                    r_state   <= StLdMsw;
                    r_oe      <= 1'b1;
                    r_databus <= {9'b0, r_target[22:16]};
                    r_busy    <= 1'b1;
                end
                StLdMsw: begin
                    r_state <= StIdle;
                end
                StIncCmd: begin
                    r_state <= StIncWait;
                    r_busy  <= 1'b1;
                end
                StIncWait: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign pcload_o     = r_pcload;
    assign pcinc_o      = r_pcinc;
    assign inc_ack_o    = r_inc_ack;
    assign br_ack_o     = r_br_ack;
    assign irq_ack_o    = r_irq_ack;
    assign databus_oe_o = r_oe;
    assign databus_o    = r_databus;
    assign busy_o       = r_busy;

    // The PC must never see both strobes at once, nor a driven value with oe low.
    a_strobes_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pcload_o && pcinc_o));
    a_bus_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
        databus_oe_o || (databus_o == 16'h0000));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: boot load, increments, branches, priority,
// stall handling and mid-sequence reset, checked against hand-computed pin vectors.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        inc_req_i;
    logic        br_req_i;
    logic [22:0] br_target_i;
    logic        irq_req_i;
    logic [6:0]  irq_idx_i;
    logic        stall_i;

    logic        inc_ack_o, br_ack_o, irq_ack_o, pcload_o, pcinc_o, databus_oe_o, busy_o;
    logic [15:0] databus_o;
    logic        bootIncAck, bootBrAck, bootIrqAck, bootPcload, bootPcinc, bootOe, bootBusy;
    logic [15:0] bootDatabus;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk_i = ~clk_i;

    pc_sequencer #(.BOOT_ADDR(23'h000000), .VEC_BASE(23'h000004)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inc_req_i(inc_req_i), .inc_ack_o(inc_ack_o),
        .br_req_i(br_req_i), .br_target_i(br_target_i), .br_ack_o(br_ack_o),
        .irq_req_i(irq_req_i), .irq_idx_i(irq_idx_i), .irq_ack_o(irq_ack_o),
        .stall_i(stall_i),
        .pcload_o(pcload_o), .pcinc_o(pcinc_o),
        .databus_o(databus_o), .databus_oe_o(databus_oe_o), .busy_o(busy_o)
    );

    pc_sequencer #(.BOOT_ADDR(23'h000200), .VEC_BASE(23'h000004)) dutBoot (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inc_req_i(inc_req_i), .inc_ack_o(bootIncAck),
        .br_req_i(br_req_i), .br_target_i(br_target_i), .br_ack_o(bootBrAck),
        .irq_req_i(irq_req_i), .irq_idx_i(irq_idx_i), .irq_ack_o(bootIrqAck),
        .stall_i(stall_i),
        .pcload_o(bootPcload), .pcinc_o(bootPcinc),
        .databus_o(bootDatabus), .databus_oe_o(bootOe), .busy_o(bootBusy)
    );

    // Pin vector layout: {pcload, pcinc, incAck, brAck, irqAck, oe, busy, databus[15:0]}
    function automatic logic [22:0] pins(input logic ld, input logic inc, input logic ia,
                                         input logic ba, input logic qa, input logic oe,
                                         input logic busy, input logic [15:0] d);
        return {ld, inc, ia, ba, qa, oe, busy, d};
    endfunction

    function automatic logic [22:0] dutPins();
        return {pcload_o, pcinc_o, inc_ack_o, br_ack_o, irq_ack_o, databus_oe_o, busy_o, databus_o};
    endfunction

    function automatic logic [22:0] bootPins();
        return {bootPcload, bootPcinc, bootIncAck, bootBrAck, bootIrqAck, bootOe, bootBusy, bootDatabus};
    endfunction

    localparam logic [22:0] IDLE = 23'h0;

    task automatic checkOutput(input string tag, input logic [22:0] observed, input logic [22:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %06h expected %06h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic br, input logic [22:0] target,
                                 input logic irq, input logic [6:0] idx, input logic stall);
        inc_req_i   = inc;
        br_req_i    = br;
        br_target_i = target;
        irq_req_i   = irq;
        irq_idx_i   = idx;
        stall_i     = stall;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        applyStimulus(1'b0, 1'b0, 23'h0, 1'b0, 7'h0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset_main", dutPins(), IDLE);
        checkOutput("reset_boot", bootPins(), IDLE);

        // Test 1: boot load after reset release
        rst_ni = 1'b1;
        checkOutput("boot_c0", bootPins(), IDLE);
        nextCycle();
        checkOutput("boot_c1_pcload", bootPins(), pins(1, 0, 0, 0, 0, 0, 1, 16'h0000));
        checkOutput("noboot_c1", dutPins(), IDLE);
        nextCycle();
        checkOutput("boot_c2_lsw", bootPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0200));
        nextCycle();
        checkOutput("boot_c3_msw", bootPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0000));
        nextCycle();
        checkOutput("boot_c4_idle", bootPins(), IDLE);
        nextCycle();
        checkOutput("boot_c5_idle", bootPins(), IDLE);

        // Test 2: back-to-back increments
        applyStimulus(1'b1, 1'b0, 23'h0, 1'b0, 7'h0, 1'b0);
        nextCycle();
        checkOutput("inc_c1", dutPins(), pins(0, 1, 1, 0, 0, 0, 1, 16'h0));
        nextCycle();
        checkOutput("inc_c2", dutPins(), pins(0, 0, 0, 0, 0, 0, 1, 16'h0));
        nextCycle();
        checkOutput("inc_c3", dutPins(), IDLE);
        nextCycle();
        checkOutput("inc_c4", dutPins(), pins(0, 1, 1, 0, 0, 0, 1, 16'h0));
        nextCycle();
        checkOutput("inc_c5", dutPins(), pins(0, 0, 0, 0, 0, 0, 1, 16'h0));
        applyStimulus(1'b0, 1'b0, 23'h0, 1'b0, 7'h0, 1'b0);
        nextCycle();
        checkOutput("inc_c6", dutPins(), IDLE);
        nextCycle();
        checkOutput("inc_c7", dutPins(), IDLE);

        // Test 3: branch with odd target
        applyStimulus(1'b0, 1'b1, 23'h12345B, 1'b0, 7'h0, 1'b0);
        nextCycle();
        checkOutput("br_cmd", dutPins(), pins(1, 0, 0, 1, 0, 0, 1, 16'h0));
        applyStimulus(1'b0, 1'b0, 23'h0, 1'b0, 7'h0, 1'b0);
        nextCycle();
        checkOutput("br_lsw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h345A));
        nextCycle();
        checkOutput("br_msw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0012));
        nextCycle();
        checkOutput("br_idle", dutPins(), IDLE);

        // Test 4: simultaneous requests resolve irq > br > inc
        applyStimulus(1'b1, 1'b1, 23'h000100, 1'b1, 7'h03, 1'b0);
        nextCycle();
        checkOutput("pri_irq_cmd", dutPins(), pins(1, 0, 0, 0, 1, 0, 1, 16'h0));
        irq_req_i = 1'b0;
        nextCycle();
        checkOutput("pri_irq_lsw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h000A));
        nextCycle();
        checkOutput("pri_irq_msw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0000));
        nextCycle();
        checkOutput("pri_idle1", dutPins(), IDLE);
        nextCycle();
        checkOutput("pri_br_cmd", dutPins(), pins(1, 0, 0, 1, 0, 0, 1, 16'h0));
        br_req_i = 1'b0;
        nextCycle();
        checkOutput("pri_br_lsw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0100));
        nextCycle();
        checkOutput("pri_br_msw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0000));
        nextCycle();
        checkOutput("pri_idle2", dutPins(), IDLE);
        nextCycle();
        checkOutput("pri_inc_cmd", dutPins(), pins(0, 1, 1, 0, 0, 0, 1, 16'h0));
        inc_req_i = 1'b0;
        nextCycle();
        checkOutput("pri_inc_wait", dutPins(), pins(0, 0, 0, 0, 0, 0, 1, 16'h0));
        nextCycle();
        checkOutput("pri_idle3", dutPins(), IDLE);

        // Test 5a: stall blocks an increment grant
        applyStimulus(1'b1, 1'b0, 23'h0, 1'b0, 7'h0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            nextCycle();
            checkOutput($sformatf("stall_c%0d", i), dutPins(), IDLE);
        end
        stall_i = 1'b0;
        nextCycle();
        checkOutput("stall_rel_inc", dutPins(), pins(0, 1, 1, 0, 0, 0, 1, 16'h0));
        inc_req_i = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("stall_rel_idle", dutPins(), IDLE);

        // Test 5b: stall raised mid-load does not cut the sequence short
        applyStimulus(1'b0, 1'b1, 23'h0ABCDE, 1'b0, 7'h0, 1'b0);
        nextCycle();
        checkOutput("stmid_cmd", dutPins(), pins(1, 0, 0, 1, 0, 0, 1, 16'h0));
        br_req_i = 1'b0;
        nextCycle();
        checkOutput("stmid_lsw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'hBCDE));
        applyStimulus(1'b1, 1'b0, 23'h0, 1'b0, 7'h0, 1'b1);
        nextCycle();
        checkOutput("stmid_msw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h000A));
        nextCycle();
        checkOutput("stmid_idle", dutPins(), IDLE);
        nextCycle();
        checkOutput("stmid_nogrant", dutPins(), IDLE);
        applyStimulus(1'b0, 1'b0, 23'h0, 1'b0, 7'h0, 1'b0);
        nextCycle();

        // Test 6: reset in the middle of a load, then the request re-arbitrates
        applyStimulus(1'b0, 1'b1, 23'h000456, 1'b0, 7'h0, 1'b0);
        nextCycle();
        checkOutput("rst_cmd", dutPins(), pins(1, 0, 0, 1, 0, 0, 1, 16'h0));
        nextCycle();
        checkOutput("rst_lsw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0456));
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_async", dutPins(), IDLE);
        nextCycle();
        checkOutput("rst_held", dutPins(), IDLE);
        rst_ni = 1'b1;
        nextCycle();
        checkOutput("rst_re_cmd", dutPins(), pins(1, 0, 0, 1, 0, 0, 1, 16'h0));
        br_req_i = 1'b0;
        nextCycle();
        checkOutput("rst_re_lsw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0456));
        nextCycle();
        checkOutput("rst_re_msw", dutPins(), pins(0, 0, 0, 0, 0, 1, 1, 16'h0000));
        nextCycle();
        checkOutput("rst_re_idle", dutPins(), IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
